// File: rtl/dbg_uart_pkg.sv
// Shared definitions for the debug UART (RX front-end and the uart_dtm TX path).
package dbg_uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_e;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int unsigned clks_per_bit(input int unsigned clk_rate,
                                               input int unsigned baud_rate);
    return (clk_rate + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous bit.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_dbg_rx.sv
// 8N1 UART receiver for the debug transport with a one-byte valid/ready holding stage.
// Framing errors and overruns are reported as single-cycle pulses; bad bytes never
// reach data_o.
module uart_dbg_rx
  import dbg_uart_pkg::*;
#(
  parameter int unsigned CLK_RATE  = 50_000_000,
  parameter int unsigned BAUD_RATE = 3_000_000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rxd_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_RATE, BAUD_RATE);
  localparam int unsigned HALF         = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       IDX_LAST  = 3'(UART_DATA_BITS - 1);

  logic rxs;

  uart_rx_state_e           state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [2:0]               idx_q;
  logic [UART_DATA_BITS-1:0] shreg_q;
  logic [UART_DATA_BITS-1:0] data_q;
  logic                     valid_q;
  logic                     ferr_q;
  logic                     ovr_q;
  logic [1:0]               fill_q;
  logic                     armed_q;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (rxd_i),
    .q_o   (rxs)
  );

  // Receive FSM, bit counters, shift register and holding stage in one registered process.
  // fill_q/armed_q make sure that after reset the line is seen high through real
  // synchroniser samples (not the flops' reset value) before a start bit is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      fill_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      fill_q <= {fill_q[0], 1'b1};
      if (fill_q[1] && rxs) armed_q <= 1'b1;

      // Consumption; a delivery below may override this in the same cycle.
      if (valid_q && ready_i) valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (armed_q && !rxs) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            if (rxs) begin
              state_q <= IDLE;          // glitch, not a start bit
            end else begin
              state_q <= DATA;
              idx_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q          <= '0;
            shreg_q[idx_q] <= rxs;
            if (idx_q == IDX_LAST) state_q <= STOP;
            else                   idx_q   <= idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (rxs) begin
              state_q <= IDLE;
              if (!valid_q || ready_i) begin
                data_q  <= shreg_q;
                valid_q <= 1'b1;
              end else begin
                ovr_q <= 1'b1;          // holding stage full: new byte dropped
              end
            end else begin
              ferr_q  <= 1'b1;
              state_q <= BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        BREAK: begin
          if (rxs) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_dbg_rx.sv
// Directed + randomized bench for uart_dbg_rx at default parameters.
module tb_uart_dbg_rx;

  localparam int CPB = (50_000_000 + 3_000_000 / 2) / 3_000_000;  // 17
  // Edges from the start-bit drive to the stop-bit sample: 2 sync + 1 detect + half bit + 9 bits.
  localparam int STOP_SAMPLE = 3 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       rxd_i;
  logic       ready_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int ferr_exp = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic       abort = 1'b0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 clk = ~clk;

  uart_dbg_rx dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .rxd_i      (rxd_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .busy_o     (busy_o)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one 8N1 frame, LSB first; abort forces the line idle for the rest of it.
  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    logic [9:0] bits;
    bits = {stop_b, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        rxd_i = abort ? 1'b1 : bits[b];
        tick(1);
      end
    end
  endtask

  task automatic cmp_bytes(input string tag);
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check({tag, "_byte"}, got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  // Output monitor: collects accepted bytes, counts pulses, checks hold stability.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_ni === 1'b1) begin
        if (frame_err_o) ferr_cnt++;
        if (overrun_o) ovr_cnt++;
        if (frame_err_o || overrun_o) begin
          checks++;
          assert ((frame_err_o & overrun_o) === 1'b0) else begin
            errors++;
            $error("FAIL flags_exclusive: observed ferr=%b ovr=%b expected not both",
                   frame_err_o, overrun_o);
          end
        end
        if (prev_hold && valid_o) check("hold_stable", data_o, prev_data);
        if (valid_o && ready_i) got.push_back(data_o);
        prev_hold = valid_o && !ready_i;
        prev_data = data_o;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic       bad;
    int         gap;

    rst_ni  = 1'b0;
    rxd_i   = 1'b1;
    ready_i = 1'b1;
    tick(3);
    check("rst_data", data_o, 8'h00);
    check("rst_valid", valid_o, 1'b0);
    check("rst_ferr", frame_err_o, 1'b0);
    check("rst_ovr", overrun_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    rst_ni = 1'b1;
    tick(10);

    // 1: single byte
    send_frame(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    tick(20);
    cmp_bytes("t1");
    check("t1_ferr", ferr_cnt, 0);
    check("t1_ovr", ovr_cnt, 0);
    check("t1_busy", busy_o, 1'b0);
    check("t1_valid", valid_o, 1'b0);

    // 2: back-to-back frames with one stop bit
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    tick(20);
    cmp_bytes("t2");
    check("t2_ferr", ferr_cnt, 0);

    // 3: 5-cycle low glitch
    rxd_i = 1'b0;
    tick(4);
    check("t3_busy_during", busy_o, 1'b1);
    tick(1);
    rxd_i = 1'b1;
    tick(3 * CPB);
    cmp_bytes("t3");
    check("t3_busy_after", busy_o, 1'b0);
    check("t3_ferr", ferr_cnt, 0);

    // 4: framing error, long break, then a good frame
    send_frame(8'h3C, 1'b0);
    rxd_i = 1'b0;
    tick(20 * CPB);
    check("t4_busy_break", busy_o, 1'b1);
    tick(20 * CPB);
    check("t4_ferr_once", ferr_cnt, 1);
    rxd_i = 1'b1;
    tick(2 * CPB);
    send_frame(8'h81, 1'b1);
    exp_q.push_back(8'h81);
    tick(20);
    cmp_bytes("t4");
    check("t4_ferr_total", ferr_cnt, 1);
    ferr_exp = 1;

    // 5: overrun, then consume-and-load in the same cycle
    ready_i = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(20);
    check("t5_valid_held", valid_o, 1'b1);
    check("t5_data_held", data_o, 8'h11);
    check("t5_ovr_once", ovr_cnt, 1);
    check("t5_none_taken", got.size(), 0);
    fork
      send_frame(8'h33, 1'b1);
      begin
        tick(STOP_SAMPLE - 1);
        ready_i = 1'b1;
      end
    join
    tick(20);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h33);
    cmp_bytes("t5");
    check("t5_ovr_total", ovr_cnt, 1);
    check("t5_valid_drained", valid_o, 1'b0);

    // 6: reset mid-DATA
    fork
      send_frame(8'h5A, 1'b1);
      begin
        tick(60);
        abort  = 1'b1;
        rst_ni = 1'b0;
        tick(2);
        check("t6_rst_data", data_o, 8'h00);
        check("t6_rst_valid", valid_o, 1'b0);
        check("t6_rst_ferr", frame_err_o, 1'b0);
        check("t6_rst_ovr", overrun_o, 1'b0);
        check("t6_rst_busy", busy_o, 1'b0);
        rst_ni = 1'b1;
      end
    join
    abort = 1'b0;
    rxd_i = 1'b1;
    tick(10);
    send_frame(8'hC3, 1'b1);
    exp_q.push_back(8'hC3);
    tick(20);
    cmp_bytes("t6");
    check("t6_ferr", ferr_cnt, ferr_exp);
    check("t6_ovr", ovr_cnt, 1);

    // Randomized frames: good frames are delivered in order, bad stop bits only flag.
    for (int n = 0; n < 12; n++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      send_frame(d, !bad);
      if (bad) begin
        ferr_exp++;
        rxd_i = 1'b0;
        tick($urandom_range(1, 3 * CPB));
        rxd_i = 1'b1;
        tick(CPB + $urandom_range(0, 20));
      end else begin
        exp_q.push_back(d);
      end
      gap = $urandom_range(0, 30);
      if (gap > 0) tick(gap);
    end
    tick(20);
    cmp_bytes("rand");
    check("rand_ferr", ferr_cnt, ferr_exp);
    check("rand_ovr", ovr_cnt, 1);
    check("rand_busy", busy_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
